serial_port_responder: RTL and testbench
========================================

# serial_port_responder

Device-side model and synthesizable endpoint of the CPU's serial-port interface. Responds to the active-low `rdn`/`wrn` strobes issued by the memory controller for address 0xBF00. Reports transmitter and receiver status on `tbre`, `tsre` and `data_ready`, which the controller folds into the 0xBF01 status word. Converts bytes to and from an 8N1 asynchronous serial line, and serves as both the board-level UART stand-in and the bench partner for controller verification.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥4, even.
- `CLK` input 1: single clock, all state on rising edge.
- `RST` input 1: reset, synchronous, active-low.
- `rdn` input 1: read strobe, active-low, from memory controller.
- `wrn` input 1: write strobe, active-low, from memory controller.
- `data` inout 16: shared data bus; driven only while `rdn`==0; bits [7:0] carry the byte, [15:8] driven 0.
- `tbre` output 1: transmit buffer empty (1 = can accept a write).
- `tsre` output 1: transmit shift register empty (1 = line idle).
- `data_ready` output 1: received byte waiting in receive buffer.
- `txd` output 1: serial out, idle high.
- `rxd` input 1: serial in, asynchronous, idle high.

## Operation
- Reset (`RST`==0 at a rising edge): `tbre`=1, `tsre`=1, `data_ready`=0, `txd`=1, bus Z, all FSMs idle, buffers 0, `wrn_q`/`rdn_q`=1. Reset mid-frame aborts the frame immediately; `txd` returns to 1 next cycle.
- Strobe edges are detected against registered copies: write event = `wrn_q`==1 && `wrn`==0; read-end event = `rdn_q`==0 && `rdn`==1.
- Write event with `tbre`==1: `data[7:0]` → tx buffer, `tbre`←0. Write event with `tbre`==0: byte dropped, no state change.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP. In TX_IDLE with `tbre`==0, move buffer → shifter, `tbre`←1, `tsre`←0, go to TX_START. TX_START drives 0 for `CLKS_PER_BIT` cycles; TX_DATA drives bits 0..7 LSB first, `CLKS_PER_BIT` each (3-bit index); TX_STOP drives 1 for `CLKS_PER_BIT`. Then: if `tbre`==0, reload directly into TX_START (back-to-back, no idle gap); otherwise TX_IDLE with `tsre`←1.
- `rxd` passes through a 2-flop synchronizer before use.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP. In RX_IDLE, a synchronized 1→0 transition enters RX_START. At half-bit (`CLKS_PER_BIT`/2) the line is re-sampled: 0 → RX_DATA; 1 → RX_IDLE (glitch). In RX_DATA, sample at every full bit period, shift in LSB first, 8 bits. RX_STOP samples the stop bit:
  - stop==1: byte → rx buffer, `data_ready`←1; overwrites an unread byte (overrun, newest wins).
  - stop==0: framing error, byte discarded, `data_ready` unchanged.
  - Either way, return to RX_IDLE at the stop sample point.
- Read: while `rdn`==0, `data` = {8'h00, rx buffer} combinationally. On a read-end event, `data_ready`←0. If a new byte is stored in the same cycle as a read-end event, the store wins: `data_ready` stays 1.
- Simultaneous write event and TX reload: the reload uses the buffer's prior content. The write is accepted only if `tbre` was 1 at that edge.

## Timing
- Write event detected at edge k: `tbre`=0 after k. If TX idle: `tbre`=1, `tsre`=0, `txd`=0 after k+1.
- Frame length: 10×`CLKS_PER_BIT` cycles. `tsre` rises on the edge that ends the stop bit.
- RX: `data_ready` rises 3 + 9.5×`CLKS_PER_BIT` cycles (±1) after the `rxd` falling edge. The 3 covers the synchronizer and edge register.
- Read data valid on `data` combinationally from `rdn` low, and stable until `rdn` high.
- `data_ready` low on the edge after `rdn` returns high.

## Structure
- Shared package `serial_pkg`: TX/RX state enum encodings, `FRAME_DATA_BITS`=8, `IDLE_LEVEL`=1'b1, status bit positions (`data_ready`=bit 1, `tbre&&tsre`=bit 0) shared with the memory controller.
- One sub-module: `serial_rx_shifter`, containing the synchronizer, RX FSM, bit counter, and sample counter. It outputs a byte plus a one-cycle `byte_valid`. TX path and bus logic stay in the top module.

## Test plan
- Reset: hold `RST`=0 two cycles → `tbre`=1, `tsre`=1, `data_ready`=0, `txd`=1, `data`=Z.
- Write 0x00A5 via `wrn` pulse (CLKS_PER_BIT=16) → `txd` carries 0,1,0,1,0,0,1,0,1,1, 16 cycles each; `tsre` high 160 cycles after start.
- Two writes 0x0031, 0x0032, one cycle after `tbre` returns 1 → two contiguous frames, no idle gap. A third write while `tbre`=0 is dropped.
- Drive `rxd` frame 0x5A → `data_ready`=1; `rdn` pulse reads `data`=0x005A; `data_ready`=0 after `rdn` high.
- Frame with stop bit 0 → `data_ready` stays 0. A 4-cycle low glitch on `rxd` → no byte stored.
- Receive 0x11 then 0x22 without reading → read returns 0x0022. Assert `RST`=0 mid-TX-frame → `txd`=1 and `tsre`=1 next cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial-port endpoint and the memory controller
// that folds its status into the 0xBF01 status word.
package serial_pkg;

    localparam int   FRAME_DATA_BITS     = 8;
    localparam logic IDLE_LEVEL          = 1'b1;
    localparam int   STAT_TX_EMPTY_BIT   = 0;
    localparam int   STAT_DATA_READY_BIT = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Packs the two status bits the way the memory controller expects them.
    function automatic logic [1:0] status_bits(input logic data_ready,
                                               input logic tbre,
                                               input logic tsre);
        logic [1:0] s;
        s                      = '0;
        s[STAT_DATA_READY_BIT] = data_ready;
        s[STAT_TX_EMPTY_BIT]   = tbre & tsre;
        return s;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// 8N1 receiver: rxd synchronizer, start-bit qualification at half-bit and
// LSB-first byte assembly. Emits a byte with a one-cycle valid on a good stop bit.
//
// state    | meaning
// RX_IDLE  | waiting for a synchronized 1->0 transition on rxd
// RX_START | counting to mid start bit, then re-checking the line
// RX_DATA  | sampling 8 data bits, one per bit period
// RX_STOP  | sampling the stop bit; byte kept only if it reads 1
module serial_rx_shifter
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       rxd_i,
    output logic [FRAME_DATA_BITS-1:0] byte_o,
    output logic                       byte_valid_o
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    rx_state_e                  state_q;
    logic [CW-1:0]              cnt_q;
    logic [2:0]                 bit_q;
    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic                       rxd_s1_q;
    logic                       rxd_s2_q;
    logic                       rxd_prev_q;
    logic                       byte_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rxd_s1_q     <= IDLE_LEVEL;
            rxd_s2_q     <= IDLE_LEVEL;
            rxd_prev_q   <= IDLE_LEVEL;
            byte_valid_q <= 1'b0;
        end else begin
            rxd_s1_q     <= rxd_i;
            rxd_s2_q     <= rxd_s1_q;
            rxd_prev_q   <= rxd_s2_q;
            byte_valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_s2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= HALF_CNT;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (!rxd_s2_q) begin
                            state_q <= RX_DATA;
                            cnt_q   <= FULL_CNT;
                            bit_q   <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rxd_s2_q, shift_q[FRAME_DATA_BITS-1:1]};
                        cnt_q   <= FULL_CNT;
                        if (bit_q == LAST_BIT) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        byte_valid_q <= rxd_s2_q;
                        state_q      <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // shift_q is frozen after the last data bit, so it is the stored byte.
    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/serial_port_responder.sv
// Serial-port endpoint for address 0xBF00: bus strobe handling, 8N1 transmitter
// with one-deep buffer, and receive buffer fed by serial_rx_shifter.
//
// state    | meaning
// TX_IDLE  | line idle; loads the buffer as soon as tbre drops
// TX_START | driving the start bit (0)
// TX_DATA  | driving data bits LSB first
// TX_STOP  | driving the stop bit (1); reloads back-to-back if buffer is full
module serial_port_responder
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rdn,
    input  logic        wrn,
    inout  wire  [15:0] data,
    output logic        tbre,
    output logic        tsre,
    output logic        data_ready,
    output logic        txd,
    input  logic        rxd
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    tx_state_e                  tx_state_q;
    logic [CW-1:0]              tx_cnt_q;
    logic [2:0]                 tx_bit_q;
    logic [FRAME_DATA_BITS-1:0] tx_buf_q;
    logic [FRAME_DATA_BITS-1:0] tx_shift_q;
    logic [FRAME_DATA_BITS-1:0] rx_buf_q;
    logic                       tbre_q;
    logic                       tsre_q;
    logic                       txd_q;
    logic                       data_ready_q;
    logic                       wrn_q;
    logic                       rdn_q;

    logic [FRAME_DATA_BITS-1:0] rx_byte;
    logic                       rx_byte_valid;
    logic                       wr_evt;
    logic                       rd_end_evt;
    logic                       unused_bus_hi;

    assign wr_evt        = wrn_q && !wrn;
    assign rd_end_evt    = !rdn_q && rdn;
    assign unused_bus_hi = ^data[15:8];

    assign data = rdn ? {16{1'bz}} : {8'h00, rx_buf_q};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_buf_q   <= '0;
            tx_shift_q <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= IDLE_LEVEL;
            wrn_q      <= 1'b1;
        end else begin
            wrn_q <= wrn;
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tbre_q) begin
                        tx_shift_q <= tx_buf_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        txd_q      <= ~IDLE_LEVEL;
                        tx_cnt_q   <= FULL_CNT;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        txd_q      <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= FULL_CNT;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= FULL_CNT;
                        if (tx_bit_q == LAST_BIT) begin
                            txd_q      <= IDLE_LEVEL;
                            tx_state_q <= TX_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[FRAME_DATA_BITS-1:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        if (!tbre_q) begin
                            tx_shift_q <= tx_buf_q;
                            tbre_q     <= 1'b1;
                            txd_q      <= ~IDLE_LEVEL;
                            tx_cnt_q   <= FULL_CNT;
                            tx_state_q <= TX_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
            // Reload only fires when tbre_q is 0, acceptance only when it is 1,
            // so the two never collide and a reload always takes the old byte.
            if (wr_evt && tbre_q) begin
                tx_buf_q <= data[FRAME_DATA_BITS-1:0];
                tbre_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_buf_q     <= '0;
            data_ready_q <= 1'b0;
            rdn_q        <= 1'b1;
        end else begin
            rdn_q <= rdn;
            if (rx_byte_valid) begin
                rx_buf_q     <= rx_byte;
                data_ready_q <= 1'b1;
            end else if (rd_end_evt) begin
                data_ready_q <= 1'b0;
            end
        end
    end

    serial_rx_shifter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (CLK),
        .rst_n_i     (RST),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_byte_valid)
    );

    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign data_ready = data_ready_q;
    assign txd        = txd_q;

endmodule

// File: tb/tb_serial_port_responder.sv
// Directed bench for serial_port_responder: TX frames decoded off txd and RX
// bytes read over the bus, each checked against queued expectations.
module tb_serial_port_responder;

    localparam int N = 16;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b0;
    logic        rdn     = 1'b1;
    logic        wrn     = 1'b1;
    logic        rxd     = 1'b1;
    logic        drv_en  = 1'b0;
    logic [15:0] drv_val = 16'h0000;
    wire  [15:0] data;
    logic        tbre;
    logic        tsre;
    logic        data_ready;
    logic        txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    assign data = drv_en ? drv_val : {16{1'bz}};

    serial_port_responder #(.CLKS_PER_BIT(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rdn       (rdn),
        .wrn       (wrn),
        .data      (data),
        .tbre      (tbre),
        .tsre      (tsre),
        .data_ready(data_ready),
        .txd       (txd),
        .rxd       (rxd)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    // Returns at the negedge just after the edge that sees wrn low.
    task automatic write_bus(input logic [15:0] val, input logic accept);
        drv_val = val;
        drv_en  = 1'b1;
        wrn     = 1'b0;
        tick();
        wrn    = 1'b1;
        drv_en = 1'b0;
        if (accept) tx_q.push_back(val[7:0]);
    endtask

    task automatic tx_frame_check(output int start_cyc);
        int         w;
        logic [7:0] got;
        w   = 0;
        got = '0;
        while (txd !== 1'b0 && w < 12 * N) begin
            tick();
            w++;
        end
        start_cyc = cyc;
        if (txd !== 1'b0) begin
            check("tx_start_timeout", {31'd0, txd}, 32'd0);
            return;
        end
        tick(N / 2);
        check("tx_start_bit", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(N);
            got[i] = txd;
        end
        tick(N);
        check("tx_stop_bit", {31'd0, txd}, 32'd1);
        check("tx_frame_expected", {31'd0, tx_q.size() != 0}, 32'd1);
        if (tx_q.size() != 0) check("tx_byte", {24'd0, got}, {24'd0, tx_q.pop_front()});
    endtask

    // Holding register model: a good frame replaces any unread byte.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(N);
        end
        rxd = stop;
        tick(N);
        rxd = 1'b1;
        tick(2);
        if (stop) begin
            if (rx_q.size() != 0) rx_q.delete(0);
            rx_q.push_back(b);
        end
    endtask

    task automatic read_check(input string tag);
        logic [7:0] expb;
        expb = '0;
        rdn  = 1'b0;
        #1;
        check("rx_expected_byte", {31'd0, rx_q.size() != 0}, 32'd1);
        if (rx_q.size() != 0) expb = rx_q.pop_front();
        check(tag, {16'd0, data}, {16'd0, 8'h00, expb});
        tick();
        check("dr_held_during_read", {31'd0, data_ready}, 32'd1);
        rdn = 1'b1;
        tick();
        check("dr_cleared_after_read", {31'd0, data_ready}, 32'd0);
    endtask

    initial begin
        int s0, s1, s2;

        tick(2);
        check("rst_tbre", {31'd0, tbre}, 32'd1);
        check("rst_tsre", {31'd0, tsre}, 32'd1);
        check("rst_data_ready", {31'd0, data_ready}, 32'd0);
        check("rst_txd", {31'd0, txd}, 32'd1);
        RST = 1'b1;
        tick(2);

        write_bus(16'h00A5, 1'b1);
        check("wr_tbre_low", {31'd0, tbre}, 32'd0);
        check("wr_tsre_still_high", {31'd0, tsre}, 32'd1);
        check("wr_txd_still_idle", {31'd0, txd}, 32'd1);
        tick();
        check("load_tbre_high", {31'd0, tbre}, 32'd1);
        check("load_tsre_low", {31'd0, tsre}, 32'd0);
        check("load_txd_start", {31'd0, txd}, 32'd0);
        tx_frame_check(s0);
        tick(N / 2 - 1);
        check("tsre_before_frame_end", {31'd0, tsre}, 32'd0);
        tick();
        check("tsre_at_frame_end", {31'd0, tsre}, 32'd1);
        tick(4);

        write_bus(16'h0031, 1'b1);
        tick();
        s1 = cyc;
        write_bus(16'h0032, 1'b1);
        check("second_write_tbre", {31'd0, tbre}, 32'd0);
        tick();
        write_bus(16'h0033, 1'b0);
        check("third_write_tbre", {31'd0, tbre}, 32'd0);
        tx_frame_check(s0);
        tx_frame_check(s2);
        check("back_to_back_spacing", s2 - s1, 10 * N);
        tick(N);
        check("no_third_frame_tsre", {31'd0, tsre}, 32'd1);
        check("no_third_frame_tbre", {31'd0, tbre}, 32'd1);
        check("tx_queue_drained", tx_q.size(), 32'd0);

        send_rx(8'h5A, 1'b1);
        check("rx_5a_ready", {31'd0, data_ready}, 32'd1);
        read_check("rx_read_5a");

        send_rx(8'h3C, 1'b0);
        tick(N);
        check("framing_error_no_ready", {31'd0, data_ready}, 32'd0);

        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(12 * N);
        check("glitch_no_ready", {31'd0, data_ready}, 32'd0);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("overrun_ready", {31'd0, data_ready}, 32'd1);
        read_check("rx_read_overrun");

        write_bus(16'h0055, 1'b1);
        tx_q.delete();
        tick(3 * N);
        check("mid_frame_txd_low", {31'd0, txd}, 32'd0);
        check("mid_frame_tsre_low", {31'd0, tsre}, 32'd0);
        RST = 1'b0;
        tick();
        check("rst_mid_frame_txd", {31'd0, txd}, 32'd1);
        check("rst_mid_frame_tsre", {31'd0, tsre}, 32'd1);
        check("rst_mid_frame_tbre", {31'd0, tbre}, 32'd1);
        RST = 1'b1;
        tick(2 * N);
        check("post_reset_txd_idle", {31'd0, txd}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
